// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive front end.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int PS2_FILTER_LEN     = 8;
    localparam int PS2_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the PS/2 lines and debounces ps2_clk.
// Emits a one-cycle fall pulse on each filtered falling edge.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic data,
    output logic fall,
    output logic data_s
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          filt;
    logic [CW-1:0] cnt;

    assign data_s = dat_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            cnt      <= '0;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], data};
            fall     <= 1'b0;
            // Any sample matching the current level restarts the run.
            if (clk_sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= clk_sync[1];
                cnt  <= '0;
                fall <= filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_frontend.sv
// PS/2 frame receiver: deserialises frames and folds E0/F0
// prefixes into one key event strobe per make or break.
module ps2_rx_frontend
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = PS2_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          fall;
    logic          data_s;
    ps2_state_e    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] tcnt;
    logic          ext_pend;
    logic          brk_pend;
    logic          timed_out;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .data    (data),
        .fall    (fall),
        .data_s  (data_s)
    );

    assign timed_out = (state != IDLE) && !fall
                    && (tcnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_ok      <= 1'b0;
            tcnt        <= '0;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_valid   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (timed_out) begin
                state     <= IDLE;
                tcnt      <= '0;
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end else begin
                if (state == IDLE || fall) begin
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                if (fall) begin
                    case (state)
                        IDLE: begin
                            if (!data_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end
                        DATA: begin
                            shreg   <= {data_s, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state <= PARITY;
                            end
                        end
                        PARITY: begin
                            par_ok <= ^{data_s, shreg};
                            state  <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            if (data_s && par_ok) begin
                                unique case (1'b1)
                                    (shreg == PS2_EXT): ext_pend <= 1'b1;
                                    (shreg == PS2_BRK): brk_pend <= 1'b1;
                                    default: begin
                                        key_code    <= shreg;
                                        key_ext     <= ext_pend;
                                        key_release <= brk_pend;
                                        key_valid   <= 1'b1;
                                        ext_pend    <= 1'b0;
                                        brk_pend    <= 1'b0;
                                    end
                                endcase
                            end else begin
                                frame_err <= 1'b1;
                                ext_pend  <= 1'b0;
                                brk_pend  <= 1'b0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/ps2_rx_frontend.md
# ps2_rx_frontend

- Receives the raw PS/2 keyboard lines in the system `clk` domain and delivers decoded key events to the keyboard key-state logic that builds the per-key status words for the LCD.
- Synchronises and glitch-filters `ps2_clk`, deserialises 11-bit frames, checks parity, stop bit and inter-bit timeout.
- Folds the E0 (extended) and F0 (break) prefix bytes into one event strobe per key press or release.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical synchronised `ps2_clk` samples required to change the filtered clock level.
- TIMEOUT_CYCLES, 50000: `clk` cycles without a filtered falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock; the block uses one clock.
- reset  in  1  synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- data  in  1  raw PS/2 data, asynchronous.
- key_code  out  8  scan code of the last event.
- key_ext  out  1  event was E0-prefixed.
- key_release  out  1  event was F0-prefixed (break).
- key_valid  out  1  one-cycle strobe; key_code, key_ext and key_release are valid while it is high.
- frame_err  out  1  one-cycle strobe on a parity, stop or timeout error.

## Operation
- Input synchronisation:
  - Each of `ps2_clk` and `data` passes through a two-flop synchroniser.
  - The filtered clock resets to 1. It changes level only after FILTER_LEN consecutive synchronised samples at the new level.
  - A falling edge is the filtered level going 1→0. It produces a one-cycle `fall` pulse.
- Frame FSM states: IDLE, DATA, PARITY, STOP. Every transition below happens on a `fall` cycle, using the synchronised `data` value.
  - IDLE: data=0 (start bit) → DATA, bit counter cleared. data=1 → remain in IDLE, no error.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: record whether the 8 data bits plus this bit have odd parity → STOP.
  - STOP: always return to IDLE.
    - Good frame (stop=1 and parity odd): process the byte.
    - Otherwise: pulse frame_err, discard the byte, clear both prefix flags.
- Timeout:
  - Applies in DATA, PARITY and STOP.
  - The idle counter resets on each `fall`.
  - When it reaches TIMEOUT_CYCLES: return to IDLE, pulse frame_err, clear both prefix flags.
  - The counter is held at 0 in IDLE.
- Byte processing:
  - 8'hE0: set ext_pend. No output.
  - 8'hF0: set brk_pend. No output.
  - Any other byte:
    - key_code ← byte, key_ext ← ext_pend, key_release ← brk_pend.
    - key_valid pulses for one cycle.
    - Both pending flags are cleared.
- key_code, key_ext and key_release hold their values until the next event.
- Reset values: every output is 0. FSM is in IDLE, counters are 0, pending flags are clear, filtered clock is 1.

## Timing
- Latency from a raw `ps2_clk` edge to `fall`: 2 synchroniser cycles + FILTER_LEN cycles, ±1 cycle.
- key_valid and frame_err are registered. They assert on the `clk` cycle after the `fall` that samples the stop bit, and last exactly one cycle.
- A timeout frame_err asserts on the cycle after the counter reaches TIMEOUT_CYCLES.
- key_valid and frame_err are never high in the same cycle.
- Reset asserted mid-frame: all state returns to reset values on the next edge. No strobe fires for the partial frame.
- Glitches shorter than FILTER_LEN cycles on `ps2_clk` produce no `fall`.

## Structure
- Package `ps2_pkg` holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - constants PS2_EXT = 8'hE0 and PS2_BRK = 8'hF0;
  - the default FILTER_LEN and TIMEOUT_CYCLES.
- Sub-module `ps2_clk_filter` holds the synchroniser, the FILTER_LEN debounce and the `fall` pulse generation. It is parameterised by FILTER_LEN.
- The top level holds the frame FSM, timeout counter, parity check and prefix handling.

## Test plan
- Frame byte 8'h1C (parity bit 0, stop 1), bit period 40 µs: key_valid for 1 cycle, key_code=8'h1C, key_ext=0, key_release=0.
- Sequence F0 then 1C: no strobe after F0. After 1C: key_valid, key_code=8'h1C, key_release=1, key_ext=0.
- Sequence E0, F0, 75: a single key_valid with key_code=8'h75, key_ext=1, key_release=1. A following plain 75 gives key_ext=0, key_release=0.
- Byte 8'h1C sent with parity bit 1: frame_err pulses, no key_valid. Same with stop bit 0. An E0 sent just before the bad frame is cleared: the next good 1C gives key_ext=0.
- Stop `ps2_clk` after 4 data bits: frame_err pulses TIMEOUT_CYCLES cycles after the last edge. A following good frame decodes correctly. Assert reset mid-frame instead: no strobe, outputs are 0.
- 3-cycle low glitches on `ps2_clk` while idle, with data=0: no state change, no strobes.
